// File: rtl/csr_spmv_ctrl.sv
// csr_spmv_ctrl: sequencer for a sparse matrix x dense vector product over CSR
// storage. Walks the row-pointer RAM, fetches value/column pairs, gathers x,
// accumulates a 64-bit signed dot product per row and streams one result per row.
// Optional build macro: CSR_PTR_CHECK_EN enables the row-pointer ordering check
// (sticky err, malformed row emitted as 0). Undefined: err is tied low.
// Result stream handshake: y_valid rises in EMIT and stays high with y_row/y_data
// frozen until a cycle in which y_ready is also high; that cycle is the transfer.
// dbg_state exposes the FSM state encoding for checkers.
module csr_spmv_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [13:0] num_rows,
  output logic [13:0] row_addra,
  output logic [13:0] row_addrb,
  input  logic [31:0] row_douta,
  input  logic [31:0] row_doutb,
  output logic [13:0] val_addr,
  output logic [13:0] col_addr,
  input  logic [31:0] val_dout,
  input  logic [31:0] col_dout,
  output logic [13:0] x_addr,
  input  logic [31:0] x_dout,
  output logic        y_valid,
  input  logic        y_ready,
  output logic [13:0] y_row,
  output logic [63:0] y_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PTR  = 3'd1,
    S_PTRW = 3'd2,
    S_VC   = 3'd3,
    S_VCW  = 3'd4,
    S_XW   = 3'd5,
    S_EMIT = 3'd6,
    S_DONE = 3'd7
  } state_t;

  state_t      state_q, state_d;
  logic [13:0] r_q, k_q, kend_q;
  logic [63:0] acc_q;
  logic [31:0] val_q;
  logic [13:0] row_a_q, row_b_q, vc_addr_q, x_addr_q;
  logic        err_q;
  logic        ptr_bad;
  logic [13:0] k_inc, r_inc;
  logic [63:0] prod;
  logic        unused_bits;

  assign k_inc = k_q + 14'd1;
  assign r_inc = r_q + 14'd1;
  // Full 32x32 signed product, both operands sign-extended to 64 bits.
  assign prod  = $signed({{32{val_q[31]}}, val_q}) * $signed({{32{x_dout[31]}}, x_dout});
  assign unused_bits = ^{row_douta[31:14], row_doutb[31:14], col_dout[31:14]};

`ifdef CSR_PTR_CHECK_EN
  assign ptr_bad = (row_doutb[13:0] < row_douta[13:0]);

  // Sticky pointer-order error, cleared when a new pass is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (state_q == S_IDLE && start) begin
      err_q <= 1'b0;
    end else if (state_q == S_PTRW && ptr_bad) begin
      err_q <= 1'b1;
    end
  end
`else
  assign ptr_bad = 1'b0;
  assign err_q   = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = (num_rows != 14'd0) ? S_PTR : S_DONE;
      S_PTR:  state_d = S_PTRW;
      S_PTRW: state_d = (ptr_bad || row_douta[13:0] == row_doutb[13:0]) ? S_EMIT : S_VC;
      S_VC:   state_d = S_VCW;
      S_VCW:  state_d = S_XW;
      S_XW:   state_d = (k_inc == kend_q) ? S_EMIT : S_VC;
      S_EMIT: if (y_ready) state_d = (r_inc == num_rows) ? S_DONE : S_PTR;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: row/nonzero indices, accumulator and held addresses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q       <= 14'd0;
      k_q       <= 14'd0;
      kend_q    <= 14'd0;
      acc_q     <= 64'd0;
      val_q     <= 32'd0;
      row_a_q   <= 14'd0;
      row_b_q   <= 14'd0;
      vc_addr_q <= 14'd0;
      x_addr_q  <= 14'd0;
    end else begin
      unique case (state_q)
        S_IDLE: if (start) begin
          r_q   <= 14'd0;
          acc_q <= 64'd0;
        end
        S_PTR: begin
          row_a_q <= r_q;
          row_b_q <= r_inc;
        end
        S_PTRW: begin
          k_q    <= row_douta[13:0];
          kend_q <= row_doutb[13:0];
        end
        S_VC:  vc_addr_q <= k_q;
        S_VCW: begin
          val_q    <= val_dout;
          x_addr_q <= col_dout[13:0];
        end
        S_XW: begin
          acc_q <= acc_q + prod;
          k_q   <= k_inc;
        end
        S_EMIT: if (y_ready) begin
          acc_q <= 64'd0;
          r_q   <= r_inc;
        end
        default: ;
      endcase
    end
  end

  // Outputs: addresses are driven live in their issue state and held otherwise.
  always_comb begin
    row_addra = row_a_q;
    row_addrb = row_b_q;
    val_addr  = vc_addr_q;
    x_addr    = x_addr_q;
    if (state_q == S_PTR) begin
      row_addra = r_q;
      row_addrb = r_inc;
    end
    if (state_q == S_VC)  val_addr = k_q;
    if (state_q == S_VCW) x_addr = col_dout[13:0];
    col_addr  = val_addr;
    y_valid   = (state_q == S_EMIT);
    y_row     = r_q;
    y_data    = acc_q;
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    err       = err_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_csr_spmv_ctrl.sv
// Bench for csr_spmv_ctrl: RAM models with one-cycle read latency, directed
// scenarios plus randomized CSR matrices checked against a dot-product model.
module tb_csr_spmv_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [13:0] num_rows;
  logic [13:0] row_addra, row_addrb, val_addr, col_addr, x_addr;
  logic [31:0] row_douta, row_doutb, val_dout, col_dout, x_dout;
  logic        y_valid, y_ready;
  logic [13:0] y_row;
  logic [63:0] y_data;
  logic        busy, done, err;
  logic [2:0]  dbg_state;

  logic [31:0] row_mem [16384];
  logic [31:0] val_mem [16384];
  logic [31:0] col_mem [16384];
  logic [31:0] x_mem   [16384];

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];

  // Clock and reset.
  always #5 clk = ~clk;

  csr_spmv_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .num_rows(num_rows),
    .row_addra(row_addra), .row_addrb(row_addrb),
    .row_douta(row_douta), .row_doutb(row_doutb),
    .val_addr(val_addr), .col_addr(col_addr),
    .val_dout(val_dout), .col_dout(col_dout),
    .x_addr(x_addr), .x_dout(x_dout),
    .y_valid(y_valid), .y_ready(y_ready), .y_row(y_row), .y_data(y_data),
    .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
  );

  // Synchronous-read RAM models.
  always @(posedge clk) begin
    row_douta <= row_mem[row_addra];
    row_doutb <= row_mem[row_addrb];
    val_dout  <= val_mem[val_addr];
    col_dout  <= col_mem[col_addr];
    x_dout    <= x_mem[x_addr];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: dot product of one CSR row with x, 64-bit wrapping sum.
  function automatic logic [63:0] model_row(input int r);
    int unsigned k, kend;
    longint acc;
    k    = row_mem[r][13:0];
    kend = row_mem[r+1][13:0];
    acc  = 0;
`ifdef CSR_PTR_CHECK_EN
    if (kend < k) return 64'd0;
`endif
    while (k != kend) begin
      acc += longint'($signed(val_mem[k])) * longint'($signed(x_mem[col_mem[k][13:0]]));
      k = (k + 1) % 16384;
    end
    return acc;
  endfunction

  // Driver: one full pass; rows checked against exp_q in order.
  task automatic run_pass(input int nrows, input string tag, input int hold_min,
                          input int hold_max, input bit poke, output int first_lat);
    int cyc, hold;
    logic [63:0] e;
    first_lat = -1;
    num_rows = 14'(nrows);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    for (int i = 0; i < nrows; i++) begin
      while (y_valid !== 1'b1 && cyc < 2000) begin
        @(negedge clk);
        cyc++;
        if (y_valid !== 1'b1) begin
          y_ready = 1'($urandom_range(0, 1));
          if (poke) start = 1'($urandom_range(0, 1));
        end
      end
      y_ready = 1'b0;
      start   = 1'b0;
      if (i == 0) first_lat = cyc;
      check($sformatf("%s_valid_r%0d", tag, i), 64'(y_valid), 64'd1);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'd0;
      check($sformatf("%s_row_r%0d", tag, i), 64'(y_row), 64'(i));
      check($sformatf("%s_data_r%0d", tag, i), y_data, e);
      hold = $urandom_range(hold_min, hold_max);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        check($sformatf("%s_hold_valid_r%0d", tag, i), 64'(y_valid), 64'd1);
        check($sformatf("%s_hold_data_r%0d", tag, i), y_data, e);
      end
      y_ready = 1'b1;
      @(negedge clk);
      y_ready = 1'b0;
      cyc = 0;
    end
    check({tag, "_done_pulse"}, 64'(done), 64'd1);
    @(negedge clk);
    check({tag, "_done_low"}, 64'(done), 64'd0);
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic load_ref_matrix();
    row_mem[0] = 32'hFFFF_C000; row_mem[1] = 32'hA5A5_C002; row_mem[2] = 32'h0000_4003;
    val_mem[0] = 32'd3; val_mem[1] = -32'sd4; val_mem[2] = 32'd5;
    col_mem[0] = 32'hABCD_0000; col_mem[1] = 32'h0000_C001; col_mem[2] = 32'd1;
    x_mem[0] = 32'd2; x_mem[1] = 32'd7;
  endtask

  // Directed and random steps.
  initial begin
    int lat, nr, ptr, cyc;
    for (int i = 0; i < 16384; i++) begin
      row_mem[i] = '0; val_mem[i] = '0; col_mem[i] = '0; x_mem[i] = '0;
    end
    reset = 1'b0; start = 1'b0; y_ready = 1'b0; num_rows = '0;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_valid", 64'(y_valid), 64'd0);
    check("rst_row", 64'(y_row), 64'd0);
    check("rst_data", y_data, 64'd0);
    check("rst_addrs", 64'({row_addra, row_addrb, val_addr, col_addr}), 64'd0);
    check("rst_xaddr", 64'(x_addr), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Reference 2x2 matrix: y = {-22, 35}.
    load_ref_matrix();
    exp_q.delete();
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFEA);
    exp_q.push_back(64'd35);
    run_pass(2, "ref", 0, 0, 0, lat);
    check("ref_err", 64'(err), 64'd0);

    // Single empty row: emitted three cycles after start, no value fetch.
    row_mem[0] = 32'h1234_4004; row_mem[1] = 32'd4;
    exp_q.delete();
    exp_q.push_back(64'd0);
    run_pass(1, "empty", 0, 1, 0, lat);
    check("empty_latency", 64'(lat), 64'd3);
    check("empty_no_vc_fetch", 64'(val_addr), 64'd2);

    // Extreme operands: 3 * (2^31-1)^2.
    row_mem[0] = 32'd0; row_mem[1] = 32'hFFFF_C003;
    for (int i = 0; i < 3; i++) begin
      val_mem[i] = 32'h7FFF_FFFF; col_mem[i] = 32'hABCD_0000;
    end
    x_mem[0] = 32'h7FFF_FFFF;
    exp_q.delete();
    exp_q.push_back(64'hBFFF_FFFD_0000_0003);
    run_pass(1, "maxmul", 0, 0, 0, lat);

    // Long backpressure with start pulses during the pass.
    load_ref_matrix();
    exp_q.delete();
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFEA);
    exp_q.push_back(64'd35);
    run_pass(2, "stall", 10, 10, 1, lat);

    // Reset while accumulating row 1.
    num_rows = 14'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (y_valid !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("abort_row0_valid", 64'(y_valid), 64'd1);
    check("abort_row0_data", y_data, 64'hFFFF_FFFF_FFFF_FFEA);
    y_ready = 1'b1;
    @(negedge clk);
    y_ready = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_valid", 64'(y_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_row", 64'(y_row), 64'd0);
    check("abort_data", y_data, 64'd0);
    check("abort_addrs", 64'({row_addra, row_addrb, val_addr, x_addr}), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    exp_q.delete();
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFEA);
    exp_q.push_back(64'd35);
    run_pass(2, "restart", 0, 2, 0, lat);

    // Decreasing pointers: 16383 -> 1 covers the wrap through address 0.
    row_mem[0] = 32'd16383; row_mem[1] = 32'd1;
    val_mem[16383] = 32'd10; col_mem[16383] = 32'd1;
    val_mem[0] = -32'sd3; col_mem[0] = 32'd0;
    x_mem[0] = 32'd2; x_mem[1] = 32'd7;
    exp_q.delete();
`ifdef CSR_PTR_CHECK_EN
    exp_q.push_back(64'd0);
    run_pass(1, "badptr", 0, 0, 0, lat);
    check("badptr_err", 64'(err), 64'd1);
`else
    exp_q.push_back(64'd64);
    run_pass(1, "wrap", 0, 0, 0, lat);
    check("wrap_err", 64'(err), 64'd0);
`endif

    // Randomized matrices against the model.
    for (int t = 0; t < 8; t++) begin
      nr  = $urandom_range(1, 5);
      ptr = $urandom_range(0, 20);
      for (int i = 0; i <= nr; i++) begin
        row_mem[i] = {18'($urandom), 14'(ptr)};
        ptr += $urandom_range(0, 4);
      end
      for (int j = 0; j < ptr; j++) begin
        val_mem[j] = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
        col_mem[j] = {18'($urandom), 14'($urandom_range(0, 15))};
      end
      for (int j = 0; j < 16; j++) x_mem[j] = $urandom;
      exp_q.delete();
      for (int i = 0; i < nr; i++) exp_q.push_back(model_row(i));
      run_pass(nr, $sformatf("rnd%0d", t), 0, 3, 1, lat);
      check($sformatf("rnd%0d_err", t), 64'(err), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
